// File: rtl/fade_pkg.sv
// Shared types for the RGB keyframe fade sequencer.
// The sequencer states and a packed colour triple at the default duty width.
package fade_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RAMP,
        HOLD
    } fade_state_t;

    localparam int DEFAULT_PWM_INTERVAL = 1250;
    localparam int RGB_W = $clog2(DEFAULT_PWM_INTERVAL + 1);

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/fade_channel.sv
// One colour channel: holds the current duty value and moves it toward a target
// by at most STEP_VAL per tick, landing exactly on the target without overshoot.
module fade_channel
    import fade_pkg::*;
#(
    parameter int VALUE_W  = RGB_W,
    parameter int STEP_VAL = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] tgt,
    input  logic               tick,
    input  logic               hold_en,
    output logic [VALUE_W-1:0] value,
    output logic               at_target
);

    localparam logic [VALUE_W:0] STEP = (VALUE_W + 1)'(STEP_VAL);

    logic [VALUE_W:0] cur_x;
    logic [VALUE_W:0] tgt_x;
    logic [VALUE_W:0] diff;
    logic [VALUE_W:0] next_x;

    assign cur_x     = {1'b0, value};
    assign tgt_x     = {1'b0, tgt};
    assign at_target = (value == tgt);

    // One extra bit of headroom keeps the step arithmetic free of wraparound.
    always_comb begin
        diff   = '0;
        next_x = cur_x;
        if (tgt_x > cur_x) begin
            diff = tgt_x - cur_x;
        end else begin
            diff = cur_x - tgt_x;
        end
        if (diff <= STEP) begin
            next_x = tgt_x;
        end else if (tgt_x > cur_x) begin
            next_x = cur_x + STEP;
        end else begin
            next_x = cur_x - STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (tick && !hold_en) begin
            value <= next_x[VALUE_W-1:0];
        end
    end

endmodule

// File: rtl/fade_sequencer.sv
// Keyframe fade controller: ramps R/G/B duty values through a loadable table
// of colours, holding each one for a fixed number of ticks, optionally looping.
module fade_sequencer
    import fade_pkg::*;
#(
    parameter int PWM_INTERVAL     = 1250,
    parameter int INC_DEC_INTERVAL = 8000,
    parameter int STEP_VAL         = 5,
    parameter int NUM_FRAMES       = 8,
    parameter int HOLD_TICKS       = 250,
    parameter int VALUE_W          = $clog2(PWM_INTERVAL + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_FRAMES)-1:0] wr_addr,
    input  logic [VALUE_W-1:0]            wr_r,
    input  logic [VALUE_W-1:0]            wr_g,
    input  logic [VALUE_W-1:0]            wr_b,
    input  logic [$clog2(NUM_FRAMES)-1:0] last_idx,
    input  logic                          loop,
    input  logic                          start,
    input  logic                          stop,
    output logic [VALUE_W-1:0]            R_value,
    output logic [VALUE_W-1:0]            G_value,
    output logic [VALUE_W-1:0]            B_value,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
    output logic                          busy,
    output logic                          done
);

    localparam int IDX_W  = $clog2(NUM_FRAMES);
    localparam int PRE_W  = $clog2(INC_DEC_INTERVAL + 1);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    logic [VALUE_W-1:0] tbl_r [NUM_FRAMES];
    logic [VALUE_W-1:0] tbl_g [NUM_FRAMES];
    logic [VALUE_W-1:0] tbl_b [NUM_FRAMES];
    logic [VALUE_W-1:0] tgt_r, tgt_g, tgt_b;

    fade_state_t        state, state_next;
    logic [IDX_W-1:0]   frame_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_next;
    logic [PRE_W-1:0]   prescaler;
    logic               done_next;
    logic               presc_clr;
    logic               load_tgt;
    logic               tick;
    logic               at_r, at_g, at_b;
    logic               channels_hold;

    function automatic logic [VALUE_W-1:0] clamp_duty(input logic [VALUE_W-1:0] v);
        return (v > VALUE_W'(PWM_INTERVAL)) ? VALUE_W'(PWM_INTERVAL) : v;
    endfunction

    assign tick          = (prescaler == PRE_W'(INC_DEC_INTERVAL - 1));
    assign busy          = (state != IDLE);
    assign channels_hold = (state != RAMP) || stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FRAMES; i++) begin
                tbl_r[i] <= '0;
                tbl_g[i] <= '0;
                tbl_b[i] <= '0;
            end
        end else if (wr_en) begin
            tbl_r[wr_addr] <= clamp_duty(wr_r);
            tbl_g[wr_addr] <= clamp_duty(wr_g);
            tbl_b[wr_addr] <= clamp_duty(wr_b);
        end
    end

    // Targets are captured once per frame so table rewrites never disturb a running ramp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_r <= '0;
            tgt_g <= '0;
            tgt_b <= '0;
        end else if (load_tgt) begin
            tgt_r <= tbl_r[frame_idx];
            tgt_g <= tbl_g[frame_idx];
            tgt_b <= tbl_b[frame_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (presc_clr || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_idx <= '0;
            hold_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            frame_idx <= frame_next;
            hold_cnt  <= hold_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        frame_next = frame_idx;
        hold_next  = hold_cnt;
        done_next  = 1'b0;
        presc_clr  = 1'b0;
        load_tgt   = 1'b0;
        if (stop) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_next = LOAD;
                        frame_next = '0;
                        presc_clr  = 1'b1;
                    end
                end
                LOAD: begin
                    load_tgt   = 1'b1;
                    state_next = RAMP;
                end
                RAMP: begin
                    if (at_r && at_g && at_b) begin
                        state_next = HOLD;
                        hold_next  = '0;
                        presc_clr  = 1'b1;
                    end
                end
                HOLD: begin
                    // last_idx and loop are only looked at here, at the advance decision.
                    if (tick) begin
                        if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                            if (frame_idx < last_idx) begin
                                frame_next = frame_idx + 1'b1;
                                state_next = LOAD;
                            end else if (loop) begin
                                frame_next = '0;
                                state_next = LOAD;
                            end else begin
                                done_next  = 1'b1;
                                state_next = IDLE;
                            end
                        end else begin
                            hold_next = hold_cnt + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    fade_channel #(.VALUE_W(VALUE_W), .STEP_VAL(STEP_VAL)) u_chan_r (
        .clk(clk), .rst_n(rst_n), .tgt(tgt_r), .tick(tick),
        .hold_en(channels_hold), .value(R_value), .at_target(at_r)
    );

    fade_channel #(.VALUE_W(VALUE_W), .STEP_VAL(STEP_VAL)) u_chan_g (
        .clk(clk), .rst_n(rst_n), .tgt(tgt_g), .tick(tick),
        .hold_en(channels_hold), .value(G_value), .at_target(at_g)
    );

    fade_channel #(.VALUE_W(VALUE_W), .STEP_VAL(STEP_VAL)) u_chan_b (
        .clk(clk), .rst_n(rst_n), .tgt(tgt_b), .tick(tick),
        .hold_en(channels_hold), .value(B_value), .at_target(at_b)
    );

endmodule

// File: tb/tb_fade_sequencer.sv
// Randomized bench for fade_sequencer: a cycle-level reference model built from
// the keyframe/tick/hold rules is compared against the design every clock.
module tb_fade_sequencer;

    localparam int PWM  = 1250;
    localparam int INTV = 4;
    localparam int STEP = 5;
    localparam int NF   = 4;
    localparam int HT   = 2;
    localparam int VW   = $clog2(PWM + 1);
    localparam int IW   = $clog2(NF);

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RAMP = 2;
    localparam int M_HOLD = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [VW-1:0] wr_r, wr_g, wr_b;
    logic [IW-1:0] last_idx;
    logic          loop;
    logic          start;
    logic          stop;
    logic [VW-1:0] R_value, G_value, B_value;
    logic [IW-1:0] frame_idx;
    logic          busy;
    logic          done;

    int checks_total  = 0;
    int checks_passed = 0;
    int done_seen     = 0;

    int m_mode, m_fidx, m_presc, m_hcnt, m_done;
    int m_cur [3];
    int m_tgt [3];
    int m_tbl [NF][3];

    int rq [$];
    int fq [$];

    fade_sequencer #(
        .PWM_INTERVAL(PWM), .INC_DEC_INTERVAL(INTV), .STEP_VAL(STEP),
        .NUM_FRAMES(NF), .HOLD_TICKS(HT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b), .last_idx(last_idx),
        .loop(loop), .start(start), .stop(stop),
        .R_value(R_value), .G_value(G_value), .B_value(B_value),
        .frame_idx(frame_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        checks_total++;
        if (observed == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int toward(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (d <= STEP && d >= -STEP) return tgt;
        return (d > 0) ? cur + STEP : cur - STEP;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_fidx = 0; m_presc = 0; m_hcnt = 0; m_done = 0;
        for (int c = 0; c < 3; c++) begin
            m_cur[c] = 0;
            m_tgt[c] = 0;
        end
        for (int f = 0; f < NF; f++)
            for (int c = 0; c < 3; c++) m_tbl[f][c] = 0;
    endtask

    // Advances the reference by one clock using the inputs currently applied.
    task automatic model_step();
        bit tick, clr;
        int nd;
        tick = (m_presc == INTV - 1);
        clr  = 0;
        nd   = 0;
        if (stop) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_mode = M_LOAD; m_fidx = 0; clr = 1;
                end
                M_LOAD: begin
                    for (int c = 0; c < 3; c++) m_tgt[c] = m_tbl[m_fidx][c];
                    m_mode = M_RAMP;
                end
                M_RAMP: begin
                    if (m_cur[0] == m_tgt[0] && m_cur[1] == m_tgt[1] && m_cur[2] == m_tgt[2]) begin
                        m_mode = M_HOLD; m_hcnt = 0; clr = 1;
                    end else if (tick) begin
                        for (int c = 0; c < 3; c++) m_cur[c] = toward(m_cur[c], m_tgt[c]);
                    end
                end
                default: if (tick) begin
                    if (m_hcnt == HT - 1) begin
                        if (m_fidx < int'(last_idx)) begin
                            m_fidx++; m_mode = M_LOAD;
                        end else if (loop) begin
                            m_fidx = 0; m_mode = M_LOAD;
                        end else begin
                            nd = 1; m_mode = M_IDLE;
                        end
                    end else begin
                        m_hcnt++;
                    end
                end
            endcase
        end
        if (wr_en) begin
            m_tbl[wr_addr][0] = (int'(wr_r) > PWM) ? PWM : int'(wr_r);
            m_tbl[wr_addr][1] = (int'(wr_g) > PWM) ? PWM : int'(wr_g);
            m_tbl[wr_addr][2] = (int'(wr_b) > PWM) ? PWM : int'(wr_b);
        end
        m_presc = (clr || tick) ? 0 : m_presc + 1;
        m_done  = nd;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_output("R", int'(R_value), m_cur[0]);
        check_output("G", int'(G_value), m_cur[1]);
        check_output("B", int'(B_value), m_cur[2]);
        check_output("frame_idx", int'(frame_idx), m_fidx);
        check_output("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
        check_output("done", int'(done), m_done);
        if (done) done_seen++;
    endtask

    task automatic apply_stimulus(input int a, input int r, input int g, input int b);
        wr_en = 1'b1; wr_addr = IW'(a);
        wr_r = VW'(r); wr_g = VW'(g); wr_b = VW'(b);
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; cycle(); stop = 1'b0;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_r(input int val, input int budget);
        int n = 0;
        while (m_cur[0] != val && n < budget) begin cycle(); n++; end
        if (m_cur[0] != val) check_output("wait_r_timeout", int'(R_value), val);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (m_mode != M_IDLE && n < budget) begin cycle(); n++; end
        if (m_mode != M_IDLE) check_output("wait_idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_state(input int mode, input int fidx, input int budget);
        int n = 0;
        while (!(m_mode == mode && m_fidx == fidx) && n < budget) begin cycle(); n++; end
        if (!(m_mode == mode && m_fidx == fidx)) check_output("wait_state_timeout", int'(frame_idx), fidx);
    endtask

    task automatic collect_r(input int want, input int budget);
        int n = 0;
        int prev;
        rq.delete();
        prev = int'(R_value);
        while (rq.size() < want && n < budget) begin
            cycle(); n++;
            if (int'(R_value) != prev) begin
                prev = int'(R_value);
                rq.push_back(prev);
            end
        end
    endtask

    function automatic int rand_val();
        if ($urandom_range(7) == 0) return int'($urandom_range(2047, 1200));
        return int'($urandom_range(60));
    endfunction

    initial begin
        int n;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_r = '0; wr_g = '0; wr_b = '0;
        last_idx = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        $display("[TB] reset and mid-ramp reset");
        check_output("init_R", int'(R_value), 0);
        check_output("init_busy", int'(busy), 0);
        apply_stimulus(0, 100, 0, 0);
        do_start();
        wait_r(40, 200);
        #3 rst_n = 1'b0;
        #1;
        check_output("rst_R", int'(R_value), 0);
        check_output("rst_frame", int'(frame_idx), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        do_start();
        wait_idle(60);
        check_output("rst_done_count", done_seen, 1);

        $display("[TB] single full ramp");
        apply_stimulus(0, 1250, 0, 0);
        done_seen = 0;
        do_start();
        n = 0;
        while (int'(R_value) != 5 && n < 20) begin cycle(); n++; end
        check_output("first_step_latency", n, 4);
        wait_idle(1200);
        check_output("full_done_count", done_seen, 1);
        check_output("full_R", int'(R_value), 1250);
        repeat (10) cycle();
        check_output("full_R_kept", int'(R_value), 1250);

        $display("[TB] saturating step");
        apply_reset();
        apply_stimulus(0, 7, 0, 0);
        do_start();
        collect_r(2, 60);
        check_output("sat_up_count", rq.size(), 2);
        if (rq.size() == 2) begin
            check_output("sat_up_0", rq[0], 5);
            check_output("sat_up_1", rq[1], 7);
        end
        wait_idle(60);
        apply_stimulus(0, 0, 0, 0);
        do_start();
        collect_r(2, 60);
        check_output("sat_dn_count", rq.size(), 2);
        if (rq.size() == 2) begin
            check_output("sat_dn_0", rq[0], 2);
            check_output("sat_dn_1", rq[1], 0);
        end
        wait_idle(60);

        $display("[TB] loop");
        apply_reset();
        apply_stimulus(0, 10, 0, 0);
        apply_stimulus(1, 0, 10, 0);
        last_idx = 1; loop = 1'b1;
        done_seen = 0;
        do_start();
        fq.delete();
        n = int'(frame_idx);
        repeat (150) begin
            cycle();
            if (int'(frame_idx) != n) begin n = int'(frame_idx); fq.push_back(n); end
        end
        check_output("loop_done_count", done_seen, 0);
        check_output("loop_frame_changes", (fq.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < fq.size() && i < 4; i++)
            check_output("loop_frame_seq", fq[i], (i % 2 == 0) ? 1 : 0);
        do_stop();
        loop = 1'b0; last_idx = 0;

        $display("[TB] stop and restart");
        apply_reset();
        apply_stimulus(0, 100, 0, 0);
        do_start();
        wait_r(20, 100);
        do_stop();
        check_output("stop_busy", int'(busy), 0);
        check_output("stop_R", int'(R_value), 20);
        repeat (12) cycle();
        check_output("stop_R_frozen", int'(R_value), 20);
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        check_output("start_stop_busy", int'(busy), 0);
        repeat (5) cycle();
        do_start();
        collect_r(2, 40);
        check_output("resume_count", rq.size(), 2);
        if (rq.size() == 2) begin
            check_output("resume_0", rq[0], 25);
            check_output("resume_1", rq[1], 30);
        end
        do_stop();

        $display("[TB] write clamp and late write");
        apply_reset();
        apply_stimulus(0, 2000, 0, 0);
        do_start();
        wait_idle(1300);
        check_output("clamp_R", int'(R_value), 1250);
        apply_stimulus(0, 10, 0, 0);
        apply_stimulus(1, 20, 0, 0);
        last_idx = 1; loop = 1'b1;
        do_start();
        wait_state(M_HOLD, 0, 1500);
        apply_stimulus(0, 30, 5, 0);
        check_output("late_R_unchanged", int'(R_value), 10);
        wait_state(M_HOLD, 1, 200);
        wait_state(M_HOLD, 0, 200);
        check_output("late_R_new", int'(R_value), 30);
        check_output("late_G_new", int'(G_value), 5);
        do_stop();

        $display("[TB] randomized sequences");
        for (int round = 0; round < 6; round++) begin
            if ($urandom_range(1) == 0) apply_reset();
            for (int f = 0; f < NF; f++) apply_stimulus(f, rand_val(), rand_val(), rand_val());
            last_idx = IW'($urandom_range(NF - 1));
            loop = 1'($urandom_range(1));
            do_start();
            repeat (400) begin
                stop  = ($urandom_range(99) < 2);
                start = ($urandom_range(99) < 3);
                if ($urandom_range(99) < 5) begin
                    wr_en = 1'b1; wr_addr = IW'($urandom_range(NF - 1));
                    wr_r = VW'(rand_val()); wr_g = VW'(rand_val()); wr_b = VW'(rand_val());
                end
                if ($urandom_range(99) < 2) begin
                    last_idx = IW'($urandom_range(NF - 1));
                    loop = 1'($urandom_range(1));
                end
                cycle();
                wr_en = 1'b0; stop = 1'b0; start = 1'b0;
            end
            do_stop();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/fade_sequencer.md
Name: fade_sequencer

Overview:
- Keyframe controller for the RGB PWM datapath.
- Holds a small table of colour keyframes and drives R/G/B duty values to the three PWM generators.
- Ramps each channel linearly from its current value to each keyframe target, holds the colour, then advances to the next keyframe, optionally looping.
- Replaces fixed-pattern fading with a software-loadable sequence.

Parameters:
- PWM_INTERVAL, 1250, PWM period in clk cycles; full-scale duty value.
- INC_DEC_INTERVAL, 8000, clk cycles per ramp/hold tick.
- STEP_VAL, 5, maximum change per channel per tick.
- NUM_FRAMES, 8, keyframe table depth.
- HOLD_TICKS, 250, ticks to hold each reached colour (≥1).
- VALUE_W, $clog2(PWM_INTERVAL+1), duty value width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  keyframe table write strobe
- wr_addr  in  $clog2(NUM_FRAMES)  keyframe index to write
- wr_r / wr_g / wr_b  in  VALUE_W each  keyframe colour
- last_idx  in  $clog2(NUM_FRAMES)  index of final keyframe in sequence
- loop  in  1  1 = wrap to frame 0 after last_idx
- start  in  1  begin sequence at frame 0
- stop  in  1  abort sequence
- R_value / G_value / B_value  out  VALUE_W each  duty values to PWM generators
- frame_idx  out  $clog2(NUM_FRAMES)  active keyframe
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at non-loop sequence end

Behaviour:
- Reset (async, rst_n low):
  - state IDLE; R/G/B_value, frame_idx, prescaler, hold counter, done all 0.
  - All table entries cleared to 0.
- Table writes:
  - Accepted on any cycle with wr_en; entry visible the next cycle.
  - Value > PWM_INTERVAL is clamped to PWM_INTERVAL at write.
  - Targets are latched in LOAD, so a write to the active frame does not affect an ongoing RAMP/HOLD.
- Tick generation:
  - Prescaler counts 0..INC_DEC_INTERVAL-1 and wraps; tick = 1-cycle pulse when prescaler == INC_DEC_INTERVAL-1.
  - Prescaler is cleared on start acceptance and on every entry to HOLD, so the first tick occurs INC_DEC_INTERVAL cycles later.
- States: IDLE, LOAD, RAMP, HOLD.
- IDLE:
  - start=1 and stop=0 -> LOAD, frame_idx=0, prescaler cleared.
  - Outputs keep last values.
- LOAD (1 cycle):
  - Latch targets tgt_r/g/b from table[frame_idx] -> RAMP.
- RAMP, on tick, per channel independently:
  - |tgt-cur| ≤ STEP_VAL -> cur=tgt.
  - else cur ± STEP_VAL toward tgt.
  - Outputs update the cycle after the tick.
  - Arithmetic in VALUE_W+1 bits; no wrap.
  - Any cycle with all three cur==tgt -> HOLD, hold_cnt=0. Includes the first RAMP cycle when targets already match, with no tick needed.
- HOLD:
  - On tick, hold_cnt++.
  - On the tick where hold_cnt == HOLD_TICKS-1, advance:
    - frame_idx < last_idx -> frame_idx+1, LOAD.
    - frame_idx ≥ last_idx, loop=1 -> frame_idx=0, LOAD.
    - frame_idx ≥ last_idx, loop=0 -> done=1 for one cycle, IDLE. frame_idx and outputs retained.
- last_idx and loop are sampled at each advance decision; changes mid-sequence take effect at the next advance.
- stop:
  - From any state, stop -> IDLE next cycle; outputs frozen; no done pulse.
  - stop and start in the same cycle: stop wins.
- start while busy: ignored.
- Restart after stop: ramps from the frozen outputs toward frame 0.

Decomposition:
- Shared package fade_pkg:
  - state enum (IDLE, LOAD, RAMP, HOLD).
  - rgb_t struct {r,g,b} of VALUE_W.
- Sub-module fade_channel, instantiated 3×:
  - Holds cur, takes tgt, tick, hold_en.
  - Outputs value and at_target.
  - Contains the saturating step logic.
- Top level contains: table, FSM, prescaler, hold counter.

Test Plan:
- Bench params unless noted: INC_DEC_INTERVAL=4, STEP_VAL=5, HOLD_TICKS=2, NUM_FRAMES=4, PWM_INTERVAL=1250.
1. Reset
   - Stimulus: assert rst_n low mid-RAMP (R=40).
   - Required: outputs, frame_idx, busy immediately 0; after release, start with unwritten table -> HOLD with all 0; done after 2 ticks.
2. Single full ramp
   - Stimulus: frame0=(1250,0,0), last_idx=0, loop=0, start.
   - Required: R=5 one cycle after first tick (cycle 4 after start); R=1250 after 250 ticks; HOLD 2 ticks; single done pulse; busy 0; R stays 1250.
3. Saturating step
   - Stimulus: frame0=(7,0,0).
   - Required: R sequence 0,5,7; no overshoot.
   - Then frame0=(0,0,0), restart: R sequence 2,0.
4. Loop
   - Stimulus: frame0=(10,0,0), frame1=(0,10,0), last_idx=1, loop=1.
   - Required: frame_idx 0,1,0,1…; in frame1 R falls 10,5,0 while G rises 0,5,10 on the same ticks; done never asserted.
5. Stop / restart
   - Stimulus: stop while R=20 ramping to 100.
   - Required: IDLE next cycle, R frozen at 20; start+stop same cycle ignored; later start resumes ramp 25,30… toward frame0.
6. Write clamp and late write
   - Stimulus: wr_r=2000 -> read back via run, R target 1250; write frame0 during its HOLD.
   - Required: current colour unchanged; new value used on next loop's LOAD.
